// File: rtl/regfile_sb.sv
// Register file with NRD registered read ports, two writeback ports and a busy-bit scoreboard.
// Reads take one cycle and forward same-edge writes; there is no backpressure and every port is accepted each cycle.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0]     r_mem [NREG];
  logic [NREG-1:0]     r_busy;
  logic [NRD*XLEN-1:0] r_rd;
  logic [NRD-1:0]      r_rbusy;

  logic                w_wr0;
  logic                w_wr1;
  logic [NREG-1:0]     w_busy_nxt;
  logic [AW-1:0]       w_ra      [NRD];
  logic [XLEN-1:0]     w_rd_nxt  [NRD];
  logic [NRD-1:0]      w_rbusy_nxt;

  // Writes to register 0 are dropped here, so no later stage needs to re-check the address.
  assign w_wr0 = we0 && (wa0 != '0);
  assign w_wr1 = we1 && (wa1 != '0);

  // Array update: port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      if (w_wr0) r_mem[wa0] <= wd0;
      if (w_wr1) r_mem[wa1] <= wd1;
    end
  end

  // Scoreboard next state: flush beats a new issue, and a new issue beats a writeback clear.
  assign w_busy_nxt[0] = 1'b0;
  for (genvar r = 1; r < NREG; r++) begin : g_busy
    logic w_set;
    logic w_clr;
    assign w_set = set_en && (set_addr == AW'(r));
    assign w_clr = (w_wr0 && (wa0 == AW'(r))) || (w_wr1 && (wa1 == AW'(r)));
    assign w_busy_nxt[r] = flush ? 1'b0 :
                           w_set ? 1'b1 :
                           w_clr ? 1'b0 : r_busy[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Read ports forward same-edge writeback data so rd and rbusy always describe the same state.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign w_ra[i] = ra[i*AW +: AW];
    assign w_rd_nxt[i] = (w_ra[i] == '0)           ? '0  :
                         (w_wr1 && wa1 == w_ra[i]) ? wd1 :
                         (w_wr0 && wa0 == w_ra[i]) ? wd0 : r_mem[w_ra[i]];
    assign w_rbusy_nxt[i] = re[i] && w_busy_nxt[w_ra[i]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_rbusy <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        r_rd[i*XLEN +: XLEN] <= re[i] ? w_rd_nxt[i] : '0;
      end
      r_rbusy <= w_rbusy_nxt;
    end
  end

  assign rd       = r_rd;
  assign rbusy    = r_rbusy;
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array/scoreboard reference model.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                set_en;
  logic [AW-1:0]       set_addr;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .re(re), .ra(ra), .rd(rd), .rbusy(rbusy),
    .set_en(set_en), .set_addr(set_addr), .flush(flush),
    .busy_vec(busy_vec)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: architectural state after each edge.
  logic [XLEN-1:0] m_mem [NREG];
  logic [NREG-1:0] m_busy;
  logic [XLEN-1:0] n_mem [NREG];
  logic [NREG-1:0] n_busy;
  logic [XLEN-1:0] exp_rd [NRD];
  logic [NRD-1:0]  exp_rbusy;

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    re = '0; ra = '0; set_en = 1'b0; set_addr = '0; flush = 1'b0;
  endtask

  task automatic set_ra(input int a1, input int a0);
    ra = {AW'(a1), AW'(a0)};
  endtask

  // Apply the current inputs for one edge, advance the model and compare all outputs.
  task automatic tick();
    logic [AW-1:0] a;
    n_mem  = m_mem;
    n_busy = m_busy;
    if (rst) begin
      for (int r = 0; r < NREG; r++) n_mem[r] = '0;
      n_busy = '0;
    end else begin
      if (we0 && wa0 != 0) n_mem[wa0] = wd0;
      if (we1 && wa1 != 0) n_mem[wa1] = wd1;
      if (we0) n_busy[wa0] = 1'b0;
      if (we1) n_busy[wa1] = 1'b0;
      if (set_en) n_busy[set_addr] = 1'b1;
      if (flush) n_busy = '0;
      n_busy[0] = 1'b0;
    end
    for (int i = 0; i < NRD; i++) begin
      a = ra[i*AW +: AW];
      if (rst || !re[i]) begin
        exp_rd[i] = '0;
        exp_rbusy[i] = 1'b0;
      end else begin
        exp_rd[i] = (a == 0) ? '0 : n_mem[a];
        exp_rbusy[i] = n_busy[a];
      end
    end
    @(posedge clk);
    #1;
    m_mem  = n_mem;
    m_busy = n_busy;
    check("rd0", 64'(rd[0 +: XLEN]), 64'(exp_rd[0]));
    check("rd1", 64'(rd[XLEN +: XLEN]), 64'(exp_rd[1]));
    check("rbusy", 64'(rbusy), 64'(exp_rbusy));
    check("busy_vec", 64'(busy_vec), 64'(m_busy));
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, NREG-1));
  endfunction

  initial begin
    for (int r = 0; r < NREG; r++) m_mem[r] = '0;
    m_busy = '0;
    idle();

    // Reset and first read.
    rst = 1'b1; tick();
    idle(); re = 2'b11; set_ra(7, 0); tick();
    check("reset_rd", 64'(rd), 64'd0);
    check("reset_busy", 64'(busy_vec), 64'd0);

    // Forwarding then array read.
    idle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF; re = 2'b01; set_ra(0, 3); tick();
    check("fwd_rd", 64'(rd[31:0]), 64'hDEADBEEF);
    idle(); re = 2'b01; set_ra(0, 3); tick();
    check("array_rd", 64'(rd[31:0]), 64'hDEADBEEF);

    // Dual write to one address: port 1 wins.
    idle(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22;
    re = 2'b10; set_ra(5, 0); tick();
    check("collide_fwd", 64'(rd[63:32]), 64'h22);
    idle(); re = 2'b11; set_ra(5, 5); tick();
    check("collide_arr", 64'(rd), {32'h22, 32'h22});

    // Set, clear, and set-beats-clear.
    idle(); set_en = 1'b1; set_addr = 5'd9; tick();
    check("set9", 64'(busy_vec[9]), 64'd1);
    idle(); re = 2'b01; set_ra(0, 9); tick();
    check("rbusy9", 64'(rbusy[0]), 64'd1);
    idle(); we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99; tick();
    check("clr9", 64'(busy_vec[9]), 64'd0);
    idle(); set_en = 1'b1; set_addr = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h98;
    re = 2'b01; set_ra(0, 9); tick();
    check("setwins9", 64'(busy_vec[9]), 64'd1);
    check("setwins_rbusy", 64'(rbusy[0]), 64'd1);

    // Flush overrides a same-cycle set.
    foreach (exp_rbusy[i]) begin end
    idle(); set_en = 1'b1; set_addr = 5'd4; tick();
    set_addr = 5'd6; tick();
    set_addr = 5'd8; tick();
    idle(); flush = 1'b1; set_en = 1'b1; set_addr = 5'd10; tick();
    check("flush", 64'(busy_vec), 64'd0);

    // Register 0 is immutable and never busy.
    idle(); we0 = 1'b1; wa0 = '0; wd0 = 32'hFFFFFFFF; set_en = 1'b1; set_addr = '0;
    re = 2'b11; set_ra(0, 0); tick();
    check("r0_fwd", 64'(rd), 64'd0);
    check("r0_busy", 64'(busy_vec[0]), 64'd0);
    idle(); re = 2'b01; set_ra(0, 0); tick();
    check("r0_arr", 64'(rd), 64'd0);

    // Reset while busy and holding data.
    idle(); set_en = 1'b1; set_addr = 5'd12; we1 = 1'b1; wa1 = 5'd13; wd1 = 32'hCAFE; tick();
    idle(); rst = 1'b1; we0 = 1'b1; wa0 = 5'd14; wd0 = 32'h1234; set_en = 1'b1; set_addr = 5'd15;
    re = 2'b11; set_ra(13, 3); tick();
    check("rst_busy", 64'(busy_vec), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    for (int r = 0; r < NREG/2; r++) begin
      idle(); re = 2'b11; set_ra(r + NREG/2, r); tick();
      check("rst_all", 64'(rd), 64'd0);
    end

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst      = ($urandom_range(0, 199) == 0);
      we0      = ($urandom_range(0, 99) < 40);
      we1      = ($urandom_range(0, 99) < 30);
      wa0      = rnd_addr();
      wa1      = rnd_addr();
      wd0      = $urandom;
      wd1      = $urandom;
      re       = NRD'($urandom_range(0, 3));
      ra       = {rnd_addr(), rnd_addr()};
      set_en   = ($urandom_range(0, 99) < 35);
      set_addr = rnd_addr();
      flush    = ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read, dual-write register file with an integrated busy-bit scoreboard for the pipelined core. Sits between decode/issue and writeback.
- Decode reads source operands through NRD synchronous read ports; issue marks destinations busy.
- Two writeback ports (ALU, load) update the array and clear busy bits.
- Same-edge write-to-read forwarding is included, so read data and busy status are always coherent.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >= 2)
AW, 5, address width (must equal log2(NREG))
NRD, 2, number of read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
we0  in  1  write enable, port 0 (ALU writeback)
wa0  in  AW  write address, port 0
wd0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1 (load writeback)
wa1  in  AW  write address, port 1
wd1  in  XLEN  write data, port 1
re  in  NRD  read enable per read port
ra  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd  out  NRD*XLEN  registered read data; port i occupies bits [i*XLEN +: XLEN]
rbusy  out  NRD  registered busy flag of the register read on each port
set_en  in  1  mark destination busy (instruction issue)
set_addr  in  AW  destination address to mark busy
flush  in  1  clear entire scoreboard (pipeline flush)
busy_vec  out  NREG  current scoreboard state, bit r = register r busy

Behaviour:
- Reset (rst=1 at edge):
  - All array entries become 0.
  - busy_vec=0, rd=0, rbusy=0.
  - rst dominates every other input.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are dropped.
  - busy_vec[0] is constant 0; set_en to address 0 is ignored.
- Writes:
  - At the edge, each port with weN=1 and waN!=0 stores wdN.
  - we0 and we1 to the same address in one cycle: port 1 wins (wd1 stored).
- Reads:
  - One-cycle latency: rd slice i is updated at the edge where re[i]=1 is sampled.
  - re[i]=0 at an edge: rd slice i <= 0 and rbusy[i] <= 0.
  - Read data priority:
    - ra[i]=0 -> 0.
    - Else, match with an active write on port 1 -> wd1.
    - Else, match with an active write on port 0 -> wd0.
    - Else, array contents.
  - All NRD ports are independent; any number may read the same address.
- Scoreboard next state per register r != 0, evaluated at each edge:
  - flush=1 -> busy[r] <= 0 (overrides set_en and clears; writes still land in the array).
  - Else set_en=1 and set_addr=r -> busy[r] <= 1. Set wins over a same-cycle clear, because it is a newer issue to the same destination.
  - Else an active write (we0/we1) to r -> busy[r] <= 0.
  - Else hold.
- rbusy[i]:
  - Registered together with rd.
  - Equals the next-state busy bit of ra[i], i.e. including this edge's set/clear/flush.
  - A forwarded read therefore reports not-busy unless a same-cycle set re-marks the register.
- busy_vec is a direct view of the scoreboard register, with no extra latency.
- No combinational path from any input to any output.

Test Plan:
- Reset, then NRD=2, re=2'b11, ra={5'd7,5'd0} -> next cycle rd all zero, rbusy=0, busy_vec=0.
- we0=1, wa0=3, wd0=0xDEADBEEF with re[0]=1, ra[0]=3 on the same edge -> rd[31:0]=0xDEADBEEF (forwarded). Re-read the following cycle -> same value from the array.
- Same cycle: we0 (wa0=5, wd0=0x11) and we1 (wa1=5, wd1=0x22) -> reg 5 reads 0x22. A same-edge read of 5 also returns 0x22.
- Set and clear of one register:
  - set_en=1, set_addr=9 -> busy_vec[9]=1; a read of 9 gives rbusy=1.
  - we1=1, wa1=9 on a later cycle -> busy_vec[9]=0.
  - set_en for 9 and we0 to 9 on the same edge -> busy_vec[9]=1.
- Set regs 4,6,8 busy. Then flush=1 with set_en=1, set_addr=10 -> busy_vec=0.
- Write to reg 0 with wd0=0xFFFFFFFF, plus set_en with set_addr=0 -> reads of 0 give 0; busy_vec[0]=0.
- Apply rst=1 while regs are busy and holding data -> next cycle busy_vec=0, rd=0, all registers read 0.
